// File: rtl/garduino_pio_pkg.sv
// Shared constants for the garduino input PIO: register word addresses and edge-capture modes.
package garduino_pio_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/garduino_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a hold-time debouncer.
// Debouncing is built only when GARDUINO_PIO_DEBOUNCE_EN is defined; otherwise stable follows sync2.
module garduino_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic stable
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign sync = sync2;

`ifdef GARDUINO_PIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign stable = sync2;
`endif

endmodule

// File: rtl/garduino_input_pio.sv
// Avalon-MM input port with per-bit synchronise/debounce, W1C edge capture and maskable level irq.
// Debounce is enabled by defining GARDUINO_PIO_DEBOUNCE_EN.
module garduino_input_pio
  import garduino_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

`ifdef GARDUINO_PIO_DEBOUNCE_EN
  localparam int unsigned ARM_LAT = DEBOUNCE_CYCLES + 2;
`else
  localparam int unsigned ARM_LAT = 2;
`endif
  localparam int unsigned AW = $clog2(ARM_LAT + 1);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;
  logic [WIDTH-1:0] hit_c;
  logic [WIDTH-1:0] clr_c;
  logic [BUS_W-1:0] rd_c;
  logic             wr_c;
  logic [AW-1:0]    arm_cnt;
  logic             armed;
  logic             unused_ok;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    garduino_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .sync   (raw[i]),
      .stable (stable[i])
    );
  end

  assign unused_ok = ^writedata;
  assign wr_c      = chipselect & ~write_n;

  // Edge selection and W1C mask for this cycle.
  always_comb begin
    rise_c = stable & ~stable_d;
    fall_c = ~stable & stable_d;
    hit_c  = rise_c | fall_c;
    clr_c  = '0;
    case (EDGE_MODE)
      EDGE_RISE: hit_c = rise_c;
      EDGE_FALL: hit_c = fall_c;
      default:   hit_c = rise_c | fall_c;
    endcase
    if (wr_c && (address == ADDR_EDGECAP)) clr_c = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_c = '0;
    case (address)
      ADDR_DATA:    rd_c = BUS_W'(stable);
      ADDR_RAW:     rd_c = BUS_W'(raw);
      ADDR_IRQMASK: rd_c = BUS_W'(irqmask);
      ADDR_EDGECAP: rd_c = BUS_W'(edgecap);
      default:      rd_c = '0;
    endcase
  end

  // Startup counter holds off edge capture until stable has settled from the reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (arm_cnt == AW'(ARM_LAT)) armed   <= 1'b1;
      else                         arm_cnt <= arm_cnt + AW'(1);
    end
  end

  // A new edge in the same cycle as a clear leaves the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      stable_d <= stable;
      readdata <= rd_c;
      edgecap  <= (edgecap & ~clr_c) | (armed ? hit_c : '0);
      if (wr_c && (address == ADDR_IRQMASK)) irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule
